// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - exhaustive built-in self-test controller for the 4-bit ALU
module alu_bist #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [7:0]  alu_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [11:0] err_count,
    output logic        fail_valid,
    output logic [10:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [10:0] LAST_IDX    = 11'd2047;

    state_t      state, state_n;
    logic [10:0] idx, idx_n;
    logic [3:0]  cnt, cnt_n;
    logic [11:0] err_n;
    logic        fv_n;
    logic [10:0] vec_n;
    logic        busy_n, done_n, pass_n;
    logic [7:0]  expected;

    function automatic logic [7:0] golden(input logic [2:0] sel,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
        logic [7:0] ax, bx, r;
        ax = {4'h0, a};
        bx = {4'h0, b};
        case (sel)
            3'b000:  r = ax + bx;
            3'b001:  r = ax - bx;
            3'b010:  r = ax * bx;
            3'b011:  r = ax & bx;
            3'b100:  r = ax | bx;
            3'b101:  r = {4'h0, ~a};
            3'b110:  r = ax ^ bx;
            default: r = {4'h0, ~(a ^ b)};
        endcase
        return r;
    endfunction

    // The vector index itself is the registered stimulus driven to the ALU
    assign {alu_sel, alu_a, alu_b} = idx;
    assign expected = golden(alu_sel, alu_a, alu_b);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        err_n   = err_count;
        fv_n    = fail_valid;
        vec_n   = fail_vec;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SETTLE;
                    idx_n   = '0;
                    cnt_n   = SETTLE_LOAD;
                    err_n   = '0;
                    fv_n    = 1'b0;
                    vec_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                end
            end
            SETTLE: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (alu_result != expected) begin
                    err_n = err_count + 12'd1;
                    if (!fail_valid) begin
                        fv_n  = 1'b1;
                        vec_n = idx;
                    end
                end
                if (idx == LAST_IDX) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == 12'd0);
                end else begin
                    idx_n   = idx + 11'd1;
                    cnt_n   = SETTLE_LOAD;
                    state_n = SETTLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            err_count  <= err_n;
            fail_valid <= fv_n;
            fail_vec   <= vec_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
        end
    end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test controller for the 4-bit ALU. It drives the ALU's operand and select inputs (`a`, `b`, `sel`) and reads back its 8-bit `result`. It exhaustively sweeps all 2048 (sel, a, b) vectors and compares each result against an internal golden model. It reports pass/fail, an error count and the first failing vector, and sits beside the ALU as its stimulus/check end for power-on and debug test.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held before the result is sampled; legal range 1–15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- `alu_a`  out  4  operand A to ALU.
- `alu_b`  out  4  operand B to ALU.
- `alu_sel`  out  3  opcode to ALU.
- `alu_result`  in  8  ALU result.
- `busy`  out  1  high while sweeping.
- `done`  out  1  high in DONE, held until next start or reset.
- `pass`  out  1  `done` and `err_count` == 0.
- `err_count`  out  12  number of mismatching vectors, 0–2048.
- `fail_valid`  out  1  at least one mismatch captured this sweep.
- `fail_vec`  out  11  {sel, a, b} of the first mismatch.

## Operation
- Golden model (operands zero-extended to 8 bits, result mod 256):
  - 000 a+b
  - 001 a−b, two's complement wrap (0−1 = 8'hFF)
  - 010 a*b
  - 011 a&b
  - 100 a|b
  - 101 {4'h0, ~a} (b ignored)
  - 110 a^b
  - 111 {4'h0, ~(a^b)}
- Vector order: b innermost, then a, then sel outermost; the 11-bit index runs 0 … 2047, with `{alu_sel, alu_a, alu_b}` = index.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE/DONE + start: clear err_count, fail_valid and fail_vec; load index 0 onto the outputs; set the settle counter to SETTLE_CYCLES; go to SETTLE.
  - SETTLE: decrement the counter; when it reaches 0, go to CHECK.
  - CHECK: compare `alu_result` with the golden value for the current outputs.
    - On mismatch: increment err_count. If fail_valid is 0, set it and capture fail_vec.
    - If index = 2047, go to DONE.
    - Otherwise increment the index (outputs change on this edge), reload the counter, and go to SETTLE.
  - DONE: outputs frozen at the last vector; wait for start.
- start is ignored while busy. err_count cannot overflow (max 2048 fits in 12 bits).

## Timing
- Reset values: alu_a/alu_b/alu_sel 0, busy 0, done 0, pass 0, err_count 0, fail_valid 0, fail_vec 0, state IDLE.
- Reset mid-sweep aborts immediately to the reset values; no partial results are retained.
- All outputs are registered.
- busy rises on the edge that samples start and falls on the edge entering DONE; done rises on that same edge.
- Per vector: SETTLE_CYCLES cycles in SETTLE + 1 cycle in CHECK. The sweep lasts 2048 × (SETTLE_CYCLES+1) cycles from the start-sampling edge to done.
- `alu_result` is sampled only in CHECK, after the inputs have been stable for ≥ SETTLE_CYCLES+1 edges. The ALU must be combinational or have latency ≤ SETTLE_CYCLES.
- err_count and fail_vec update on the CHECK edge. pass is valid whenever done = 1.

## Test plan
- Correct behavioural ALU, SETTLE_CYCLES=1, pulse start → done after exactly 4096 cycles; pass=1, err_count=0, fail_valid=0; final outputs sel=7, a=15, b=15.
- ALU fault: sel=101 returns 8'hFF → err_count=256, fail_vec={3'b101,4'h0,4'h0}, pass=0.
- ALU fault: SUB without wrap (0−1 returns 8'h00) → first fail_vec={3'b001,4'h0,4'h1}; err_count equals the number of a<b pairs, 120.
- Pulse start again 50 cycles into a sweep → ignored; sweep completes at the original 4096-cycle mark with a single result.
- Assert rst at cycle 100 of a sweep → all outputs 0 and IDLE within the same cycle. A subsequent start completes a full clean sweep with pass=1.
- SETTLE_CYCLES=3: start from DONE after a failing sweep → err_count/fail_valid cleared on the start edge; done after 8192 cycles with pass=1.
